// File: rtl/jt6295_interpol_if.sv
// Sample-rate strobes and audio bus between jt6295 and
// its interpolating output stage.
interface jt6295_interpol_if;
  logic               cen_in;
  logic signed [13:0] snd_in;
  logic               cen_out;
  logic signed [13:0] snd_out;
  logic               snd_ok;

  modport master (
    output cen_in, snd_in, cen_out,
    input  snd_out, snd_ok
  );

  modport slave (
    input  cen_in, snd_in, cen_out,
    output snd_out, snd_ok
  );
endinterface

// File: rtl/jt6295_interpol.sv
// jt6295 output stage: optional DC-removal high-pass
// followed by a linear upsampler of 2^STEPS_LOG2.
module jt6295_interpol #(
  parameter int STEPS_LOG2 = 2,
  parameter int DCRM       = 0,
  parameter int DCK        = 8
) (
  input  logic           clk,
  input  logic           rst,
  jt6295_interpol_if.slave bus
);

  localparam int PW = 16 + STEPS_LOG2;
  localparam logic [STEPS_LOG2-1:0] PMAX = '1;
  localparam logic [STEPS_LOG2-1:0] PONE = STEPS_LOG2'(1);

  logic signed [13:0]         prev, curr, filt, x1;
  logic signed [16:0]         y1, dc_y, xe, x1e;
  logic [STEPS_LOG2-1:0]      phase, p;
  logic signed [13:0]         a, b;
  logic signed [14:0]         diff;
  logic signed [PW-1:0]       prod, sum;

  always_comb begin
    xe   = {{3{bus.snd_in[13]}}, bus.snd_in};
    x1e  = {{3{x1[13]}}, x1};
    dc_y = xe - x1e + y1 - (y1 >>> DCK);
    filt = bus.snd_in;
    if (DCRM != 0) begin
      if (dc_y > 17'sd8191)
        filt = 14'sd8191;
      else if (dc_y < -17'sd8192)
        filt = -14'sd8192;
      else
        filt = dc_y[13:0];
    end
  end

  // A coincident cen_in is latched first, so the
  // output sees the new pair at phase 0.
  always_comb begin
    a    = bus.cen_in ? curr : prev;
    b    = bus.cen_in ? filt : curr;
    p    = bus.cen_in ? '0 : phase;
    diff = {b[13], b} - {a[13], a};
    prod = PW'(diff) * PW'($signed({1'b0, p}));
    sum  = PW'(a) + (prod >>> STEPS_LOG2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      curr        <= '0;
      phase       <= '0;
      x1          <= '0;
      y1          <= '0;
      bus.snd_out <= '0;
      bus.snd_ok  <= 1'b0;
    end else begin
      bus.snd_ok <= bus.cen_out;
      if (bus.cen_in) begin
        prev  <= curr;
        curr  <= filt;
        phase <= bus.cen_out ? PONE : '0;
        if (DCRM != 0) begin
          x1 <= bus.snd_in;
          y1 <= dc_y;
        end
      end else if (bus.cen_out && phase != PMAX) begin
        phase <= phase + PONE;
      end
      if (bus.cen_out)
        bus.snd_out <= sum[13:0];
    end
  end

endmodule

// File: tb/tb_jt6295_interpol.sv
// Directed vector bench for jt6295_interpol: plain
// interpolator plus a DC-removal instance.
module tb_jt6295_interpol;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jt6295_interpol_if b0();
  jt6295_interpol_if b1();

  jt6295_interpol #(.STEPS_LOG2(2), .DCRM(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  jt6295_interpol #(.STEPS_LOG2(2), .DCRM(1), .DCK(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct {
    logic               cin;
    logic signed [13:0] sin;
    logic               cout;
    logic               ok;
    logic signed [13:0] out;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive0(input logic cin, input logic signed [13:0] sin,
                        input logic cout);
    b0.cen_in  = cin;
    b0.snd_in  = sin;
    b0.cen_out = cout;
    @(posedge clk);
    #1;
    b0.cen_in  = 1'b0;
    b0.cen_out = 1'b0;
  endtask

  // DC filter reference, full integer precision
  int dc_x1 = 0, dc_y1 = 0, dc_last = 0;

  task automatic dc_push(input int x, input bit do_chk, input string n);
    int y, f;
    b1.cen_in  = 1'b1;
    b1.cen_out = 1'b1;
    b1.snd_in  = 14'(x);
    @(posedge clk);
    #1;
    b1.cen_in  = 1'b0;
    b1.cen_out = 1'b0;
    if (do_chk) chk(n, int'(b1.snd_out), dc_last);
    y = x - dc_x1 + dc_y1 - (dc_y1 >>> 8);
    f = (y > 8191) ? 8191 : (y < -8192) ? -8192 : y;
    dc_x1   = x;
    dc_y1   = y;
    dc_last = f;
  endtask

  initial begin
    v[0]  = '{1'b1, 14'sd0,     1'b0, 1'b0, 14'sd0};
    v[1]  = '{1'b1, 14'sd400,   1'b0, 1'b0, 14'sd0};
    v[2]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd0};
    v[3]  = '{1'b0, 14'sd0,     1'b0, 1'b0, 14'sd0};
    v[4]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd100};
    v[5]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd200};
    v[6]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd300};
    v[7]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd300};
    v[8]  = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd300};
    v[9]  = '{1'b1, 14'sd8191,  1'b0, 1'b0, 14'sd300};
    v[10] = '{1'b1, -14'sd8192, 1'b0, 1'b0, 14'sd300};
    v[11] = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd8191};
    v[12] = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd4095};
    v[13] = '{1'b0, 14'sd0,     1'b1, 1'b1, -14'sd1};
    v[14] = '{1'b0, 14'sd0,     1'b1, 1'b1, -14'sd4097};
    v[15] = '{1'b1, 14'sd100,   1'b0, 1'b0, -14'sd4097};
    v[16] = '{1'b1, 14'sd200,   1'b1, 1'b1, 14'sd100};
    v[17] = '{1'b0, 14'sd0,     1'b1, 1'b1, 14'sd125};

    rst = 1'b1;
    b0.cen_in = 1'b0; b0.cen_out = 1'b0; b0.snd_in = '0;
    b1.cen_in = 1'b0; b1.cen_out = 1'b0; b1.snd_in = '0;
    #1;
    chk("rst_out0", int'(b0.snd_out), 0);
    chk("rst_ok0", int'(b0.snd_ok), 0);
    chk("rst_out1", int'(b1.snd_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive0(v[i].cin, v[i].sin, v[i].cout);
      chk($sformatf("vec%0d_out", i), int'(b0.snd_out), int'(v[i].out));
      chk($sformatf("vec%0d_ok", i), int'(b0.snd_ok), int'(v[i].ok));
    end

    // mid-stream reset between cen_out pulses
    drive0(1'b0, 14'sd0, 1'b1);
    chk("pre_rst_out", int'(b0.snd_out), 150);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", int'(b0.snd_out), 0);
    chk("mid_rst_ok", int'(b0.snd_ok), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive0(1'b1, 14'sd0, 1'b0);
    drive0(1'b1, 14'sd400, 1'b0);
    drive0(1'b0, 14'sd0, 1'b1);
    chk("restart_out0", int'(b0.snd_out), 0);
    chk("restart_ok0", int'(b0.snd_ok), 1);
    drive0(1'b0, 14'sd0, 1'b1);
    chk("restart_out1", int'(b0.snd_out), 100);

    // DC removal: long constant input, then a full-scale step
    for (int i = 0; i < 2048; i++)
      dc_push(1000, (i < 3) || (i % 256 == 255), $sformatf("dc%0d", i));
    dc_push(8191, 1'b1, "dc_settled");
    dc_push(-8192, 1'b1, "dc_pos_step");
    dc_push(0, 1'b1, "dc_neg_sat");
    chk("dc_neg_sat_val", int'(b1.snd_out), -8192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
